// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM states,
// channel index map and default timing parameters.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_DISARMING = 2'd3
  } btn_state_e;

  localparam int NUM_BTN = 4;

  // Bit positions of {BtnU, BtnD, BtnL, BtnR} in the button vectors.
  localparam int IDX_U = 3;
  localparam int IDX_D = 2;
  localparam int IDX_L = 1;
  localparam int IDX_R = 0;

  // 10 ms qualification and 0.5 s auto-repeat at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int REPEAT_CYCLES_DEF   = 50000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with a qualification
// counter, and an auto-repeat counter while the button stays held.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | released and stable; waiting for s=1
// ST_ARMING    | s=1 seen, counting stable-high clocks toward a press
// ST_HELD      | qualified press; repeat counter running
// ST_DISARMING | s=0 seen while held, counting stable-low clocks to release
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic btn_raw_i,
  output logic db_level_o,
  output logic press_pulse_o,
  output logic repeat_pulse_o,
  output logic release_pulse_o
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES);
  localparam int REPW = $clog2(REPEAT_CYCLES);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [REPW-1:0] REP_LAST = REPW'(REPEAT_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            s;
  btn_state_e      state_q, state_d;
  logic [DBW-1:0]  db_cnt_q, db_cnt_d;
  logic [REPW-1:0] rep_cnt_q, rep_cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            repeat_q, repeat_d;
  logic            release_q, release_d;

  assign s = sync_q[1];

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sync_q    <= '0;
      state_q   <= ST_IDLE;
      db_cnt_q  <= '0;
      rep_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw_i};
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    rep_cnt_d = rep_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        db_cnt_d = '0;
        if (s) state_d = ST_ARMING;
      end
      ST_ARMING: begin
        if (!s) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_HELD;
          db_cnt_d  = '0;
          rep_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d  = ST_DISARMING;
          db_cnt_d = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      ST_DISARMING: begin
        // A bounce back to 1 resumes holding with a fresh repeat period.
        if (s) begin
          state_d   = ST_HELD;
          db_cnt_d  = '0;
          rep_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        db_cnt_d  = '0;
        rep_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the transition and registered on the same edge.
  always_comb begin
    press_d   = (state_q == ST_ARMING) && (state_d == ST_HELD);
    repeat_d  = press_d ||
                ((state_q == ST_HELD) && (state_d == ST_HELD) && (rep_cnt_q == REP_LAST));
    release_d = (state_q == ST_DISARMING) && (state_d == ST_IDLE);
    level_d   = (state_d == ST_HELD) || (state_d == ST_DISARMING);
  end

  assign db_level_o      = level_q;
  assign press_pulse_o   = press_q;
  assign repeat_pulse_o  = repeat_q;
  assign release_pulse_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Four independent debounced push-button channels {U, D, L, R} with press,
// auto-repeat and release pulses, plus an any-button-held summary.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic               ClkPort,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] db_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               any_held
);

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_btn_u (
    .ClkPort        (ClkPort),
    .Reset          (Reset),
    .btn_raw_i      (btn_raw[IDX_U]),
    .db_level_o     (db_level[IDX_U]),
    .press_pulse_o  (press_pulse[IDX_U]),
    .repeat_pulse_o (repeat_pulse[IDX_U]),
    .release_pulse_o(release_pulse[IDX_U])
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_btn_d (
    .ClkPort        (ClkPort),
    .Reset          (Reset),
    .btn_raw_i      (btn_raw[IDX_D]),
    .db_level_o     (db_level[IDX_D]),
    .press_pulse_o  (press_pulse[IDX_D]),
    .repeat_pulse_o (repeat_pulse[IDX_D]),
    .release_pulse_o(release_pulse[IDX_D])
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_btn_l (
    .ClkPort        (ClkPort),
    .Reset          (Reset),
    .btn_raw_i      (btn_raw[IDX_L]),
    .db_level_o     (db_level[IDX_L]),
    .press_pulse_o  (press_pulse[IDX_L]),
    .repeat_pulse_o (repeat_pulse[IDX_L]),
    .release_pulse_o(release_pulse[IDX_L])
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_btn_r (
    .ClkPort        (ClkPort),
    .Reset          (Reset),
    .btn_raw_i      (btn_raw[IDX_R]),
    .db_level_o     (db_level[IDX_R]),
    .press_pulse_o  (press_pulse[IDX_R]),
    .repeat_pulse_o (repeat_pulse[IDX_R]),
    .release_pulse_o(release_pulse[IDX_R])
  );

  assign any_held = |db_level;

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), stable-level qualification time in clocks; SHALL be >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 50000000 (0.5 s), auto-repeat period in clocks while held; SHALL be >= 2.
REQ-003 ClkPort  in  1  system clock, 100 MHz.
REQ-004 Reset  in  1  reset Reset, asynchronous, active-high; clock ClkPort.
REQ-005 btn_raw  in  4  raw push-buttons {BtnU, BtnD, BtnL, BtnR}, bit 3 = U, bit 0 = R, asynchronous to ClkPort.
REQ-006 db_level  out  4  debounced button level per channel.
REQ-007 press_pulse  out  4  one-clock pulse on qualified press.
REQ-008 repeat_pulse  out  4  one-clock pulse on qualified press and every REPEAT_CYCLES while held.
REQ-009 release_pulse  out  4  one-clock pulse on qualified release.
REQ-010 any_held  out  1  OR of db_level.

Function
REQ-011 Each channel SHALL be independent and identical; no cross-channel interaction.
REQ-012 Each raw input SHALL pass a 2-flop synchronizer; output s is the only signal used by the FSM.
REQ-013 Per-channel FSM states: IDLE, ARMING, HELD, DISARMING.
REQ-014 IDLE: on s=1 go ARMING with debounce count 0.
REQ-015 ARMING: count +1 per clock while s=1; s=0 returns to IDLE (count cleared); at count=DEBOUNCE_CYCLES-1 with s=1 go HELD.
REQ-016 Entering HELD SHALL assert press_pulse and repeat_pulse for exactly one clock and set db_level=1, all registered on the transition edge.
REQ-017 Latency: with the first edge sampling raw=1 numbered 1, press_pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+3.
REQ-018 HELD: repeat counter counts from 0 at entry; when it reaches REPEAT_CYCLES-1 assert repeat_pulse one clock and wrap to 0; s=0 goes DISARMING.
REQ-019 DISARMING: db_level stays 1, no repeat pulses; count +1 per clock while s=0; s=1 returns to HELD with repeat counter cleared and no pulse; at count=DEBOUNCE_CYCLES-1 with s=0 go IDLE.
REQ-020 Entering IDLE from DISARMING SHALL assert release_pulse one clock and clear db_level on the same edge.
REQ-021 Any raw pulse or gap shorter than DEBOUNCE_CYCLES+1 clocks of s SHALL produce no output change.
REQ-022 Counters SHALL be sized by $clog2 of their parameter; no wrap other than REQ-018.
REQ-023 Simultaneous presses on several channels SHALL yield pulses in the same cycle.

Reset
REQ-024 Reset SHALL clear synchronizers, counters, FSMs to IDLE, and every output to 0 immediately.
REQ-025 Reset mid-operation SHALL abort without emitting release_pulse; a button held through reset deassertion SHALL be requalified per REQ-017 from the first post-reset edge.

Structure
REQ-026 Shared package btn_pkg SHALL hold the FSM state enum, channel index constants (IDX_U=3, IDX_D=2, IDX_L=1, IDX_R=0) and default parameter values.
REQ-027 Sub-module btn_debounce_ch SHALL implement one channel (sync, FSM, counters); btn_conditioner instantiates four and forms any_held.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-028 Reset deasserted, btn_raw=0 for 50 clocks -> all outputs 0 throughout.
REQ-029 btn_raw[3] rises and stays -> press_pulse[3] and repeat_pulse[3] high one cycle after edge 7, repeat_pulse[3] again after edges 17 and 27, db_level[3]=1 from edge 7.
REQ-030 btn_raw[0] high 3 clocks then low (glitch), and bounce pattern 1,0,1,0 -> no pulses, db_level[0]=0.
REQ-031 Held btn_raw[1] released with a 2-clock re-bounce to 1 -> no release, repeat counter restarts; clean release -> release_pulse[1] once, db_level[1]=0.
REQ-032 btn_raw[2] and btn_raw[1] rise same edge -> press_pulse=4'b0110 in one cycle, any_held=1.
REQ-033 Reset asserted while HELD -> outputs 0 immediately, no release_pulse; button still held -> press_pulse after edge 7 post-reset.
